aes_sub_bytes_seq: RTL and testbench

//  Forward AES SubBytes stage for the encryption datapath; the encrypt-side counterpart of the inverse S-box.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/aes_sbox_fwd.sv | 34 +++
 rtl/aes_sub_bytes_seq.sv | 95 +++++++++
 tb/tb_aes_sub_bytes_seq.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, byte-order helpers and the SubBytes FSM encoding.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sub_state_e;

    localparam int AES_BYTES = 16;

    // Byte 0 of the FIPS state sits in the top byte of the vector.
    function automatic aes_byte_t get_byte(input aes_state_t s, input int i);
        return s[127-8*i -: 8];
    endfunction

    function automatic aes_state_t set_byte(input aes_state_t s, input int i, input aes_byte_t b);
        aes_state_t r;
        r = s;
        r[127-8*i -: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox_fwd.sv
// Forward AES S-box: purely combinational 256-entry lookup.
module aes_sbox_fwd
    import aes_pkg::*;
(
    input  aes_byte_t din,
    output aes_byte_t dout
);

    // Row r holds S(0xr0) .. S(0xrF); entry 0x00 is the top byte.
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Index the table from the top, matching the row layout above.
    always_comb begin
        dout = TBL[2047 - 8*int'(din) -: 8];
    end

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// Sequential AES SubBytes: substitutes LANES bytes per cycle in place,
// one 128-bit transaction in flight, valid/ready on both sides.
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int BEATS = (LANES < 1) ? AES_BYTES : AES_BYTES / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES < 1) begin : g_bad_lanes_lo
        $error("aes_sub_bytes_seq: LANES must be at least 1");
    end else if (AES_BYTES % LANES != 0) begin : g_bad_lanes_div
        $error("aes_sub_bytes_seq: LANES must divide 16");
    end

    sub_state_e              state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    aes_state_t              work, work_nxt;
    logic [LANES-1:0][7:0]   lane_in, lane_out;

    // One S-box per lane, all looking at the current beat's byte window.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_in[k] = get_byte(work, int'(cnt)*LANES + k);
        aes_sbox_fwd u_sbox (
            .din  (lane_in[k]),
            .dout (lane_out[k])
        );
    end

    // State, beat counter and work register; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            work  <= work_nxt;
        end
    end

    // Next state: load on accept, rewrite one byte window per beat, hold in DONE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        work_nxt  = work;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    work_nxt  = in_state;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < LANES; k++) begin
                    work_nxt = set_byte(work_nxt, int'(cnt)*LANES + k, lane_out[k]);
                end
                if (cnt == CW'(BEATS-1)) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are forced quiet while reset is held.
    always_comb begin
        in_ready  = !rst && (state == IDLE);
        out_valid = !rst && (state == DONE);
        busy      = !rst && ((state == BUSY) || (state == DONE));
        out_state = out_valid ? work : '0;
    end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Bench for aes_sub_bytes_seq: S-box model derived from GF(2^8) arithmetic,
// per-cycle handshake/timing model, directed corners plus random traffic,
// and a LANES sweep on extra instances.
module tb_aes_sub_bytes_seq;

    localparam int LANES = 4;
    localparam int BEATS = 16 / LANES;
    localparam logic [127:0] V1     = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int rmode    = 0;
    int sweep_done = 0;

    logic [7:0]   fwd_t [256];
    logic [7:0]   inv_t [256];
    logic [127:0] recv_q [$];
    logic [127:0] exp_q  [$];

    always #5 clk = ~clk;

    aes_sub_bytes_seq #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S(x) = affine(x^-1) over GF(2^8) with the AES polynomial.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] subbytes_m(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fwd_t[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] invbytes_m(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_t[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) fwd_t[x] = sbox_calc(8'(x));
        for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);
    end

    // Downstream ready policy: 0 always ready, 1 stalled, 2 random.
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Reference: a transaction is pending from accept until handoff; result
    // appears BEATS edges after the accept edge and is held until out_ready.
    bit           m_pend = 1'b0;
    int           m_rem  = 0;
    logic [127:0] m_exp  = '0;

    always @(negedge clk) begin
        bit e_ir, e_ov, e_busy;
        e_ir   = !rst && !m_pend;
        e_ov   = !rst && m_pend && (m_rem == 0);
        e_busy = !rst && m_pend;
        chk("in_ready",  {127'd0, in_ready},  {127'd0, e_ir});
        chk("out_valid", {127'd0, out_valid}, {127'd0, e_ov});
        chk("busy",      {127'd0, busy},      {127'd0, e_busy});
        if (rst)  chk("out_state_rst", out_state, '0);
        if (e_ov) chk("out_state", out_state, m_exp);
        if (!rst && out_valid && out_ready) recv_q.push_back(out_state);
        if (rst) begin
            m_pend = 1'b0;
        end else if (!m_pend) begin
            if (in_valid) begin
                m_pend = 1'b1;
                m_rem  = BEATS;
                m_exp  = subbytes_m(in_state);
            end
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (out_ready) begin
            m_pend = 1'b0;
        end
    end

    task automatic send(input logic [127:0] s);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_state = s;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 128'd1, 128'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = rnd128();
    endtask

    task automatic wait_recv(input int n);
        int k;
        k = 0;
        while (recv_q.size() < n) begin
            @(negedge clk);
            k++;
            if (k > 500) begin
                chk("recv_timeout", 128'(recv_q.size()), 128'(n));
                break;
            end
        end
    endtask

    task automatic wait_ov();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 100);
        if (!out_valid) chk("ov_timeout", 128'd0, 128'd1);
    endtask

    // Latency and result for other lane counts, each on its own instance.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int LG = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
        logic         s_iv = 1'b0;
        logic         s_ir, s_ov, s_busy;
        logic [127:0] s_in = '0;
        logic [127:0] s_out;

        aes_sub_bytes_seq #(.LANES(LG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (s_iv),
            .in_ready  (s_ir),
            .in_state  (s_in),
            .out_valid (s_ov),
            .out_ready (1'b1),
            .out_state (s_out),
            .busy      (s_busy)
        );

        initial begin
            int n;
            n = 0;
            @(negedge clk);
            while (rst && n < 100) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            s_iv = 1'b1;
            s_in = V1;
            @(negedge clk);
            chk($sformatf("sweep%0d_ready", LG), {127'd0, s_ir}, 128'd1);
            @(posedge clk);
            #1;
            s_iv = 1'b0;
            s_in = rnd128();
            n = 0;
            forever begin
                @(negedge clk);
                if (s_ov || n > 40) break;
                @(posedge clk);
                n++;
            end
            chk($sformatf("sweep%0d_latency", LG), 128'(n), 128'(16 / LG));
            chk($sformatf("sweep%0d_result", LG), s_out, V1_OUT);
            sweep_done++;
        end
    end

    initial begin
        logic [127:0] got, snap, s, e;
        logic [7:0] pin [3];
        logic [7:0] pout [3];
        int k;
        pin  = '{8'h00, 8'h01, 8'h53};
        pout = '{8'h63, 8'h7c, 8'hed};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Model pins against hand values.
        chk("pin_s00", {120'd0, fwd_t[8'h00]}, 128'h63);
        chk("pin_sff", {120'd0, fwd_t[8'hff]}, 128'h16);
        chk("pin_s53", {120'd0, fwd_t[8'h53]}, 128'hed);
        chk("pin_inv", {120'd0, inv_t[8'h7c]}, 128'h01);
        chk("pin_vec1", subbytes_m(V1), V1_OUT);

        // FIPS-197 vector.
        rmode = 0;
        send(V1);
        wait_recv(1);
        got = recv_q.pop_front();
        chk("fips_vec1", got, V1_OUT);

        // Corners.
        send('0);
        wait_recv(1);
        got = recv_q.pop_front();
        chk("all00", got, {16{8'h63}});
        send('1);
        wait_recv(1);
        got = recv_q.pop_front();
        chk("allff", got, {16{8'h16}});
        for (int off = 0; off < 3; off++) begin
            for (int i = 0; i < 16; i++) begin
                s[127-8*i -: 8] = pin[(i + off) % 3];
                e[127-8*i -: 8] = pout[(i + off) % 3];
            end
            send(s);
            wait_recv(1);
            got = recv_q.pop_front();
            chk($sformatf("pattern_off%0d", off), got, e);
        end

        // Backpressure in DONE with in_valid hammered.
        rmode = 1;
        send(V1);
        wait_ov();
        snap = out_state;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_state = rnd128();
            @(negedge clk);
            chk("bp_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_hold", out_state, snap);
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rmode = 0;
        wait_recv(1);
        got = recv_q.pop_front();
        chk("bp_result", got, V1_OUT);

        // Reset during BUSY at beat 2.
        send(V1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy_ov", {127'd0, out_valid}, 128'd0);
        chk("rst_busy_busy", {127'd0, busy}, 128'd0);
        repeat (8) @(negedge clk);
        chk("rst_busy_nostale", 128'(recv_q.size()), 128'd0);
        send(V1);
        wait_recv(1);
        got = recv_q.pop_front();
        chk("rst_busy_next", got, V1_OUT);

        // Reset while holding a result in DONE.
        rmode = 1;
        send('1);
        wait_ov();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rmode = 0;
        repeat (8) @(negedge clk);
        chk("rst_done_nostale", 128'(recv_q.size()), 128'd0);

        // All 256 byte values, back to back, round-tripped through the inverse.
        for (int t = 0; t < 16; t++) begin
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = 8'(t*16 + i);
            exp_q.push_back(s);
            send(s);
        end
        wait_recv(16);
        for (int t = 0; t < 16 && recv_q.size() > 0; t++) begin
            got = recv_q.pop_front();
            s = exp_q.pop_front();
            chk($sformatf("exh_model%0d", t), got, subbytes_m(s));
            chk($sformatf("exh_inv%0d", t), invbytes_m(got), s);
        end
        exp_q.delete();

        // Random traffic with random gaps and random backpressure.
        rmode = 2;
        for (int t = 0; t < 40; t++) begin
            s = rnd128();
            exp_q.push_back(subbytes_m(s));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                in_state = rnd128();
            end
            send(s);
        end
        wait_recv(40);
        k = 0;
        while (recv_q.size() > 0 && exp_q.size() > 0) begin
            got = recv_q.pop_front();
            chk($sformatf("rand%0d", k), got, exp_q.pop_front());
            k++;
        end
        chk("rand_count", 128'(k), 128'd40);

        k = 0;
        while (sweep_done < 4 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("sweep_done", 128'(sweep_done), 128'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
